// File: rtl/gemm_tile_sched.sv
// Walks an M x N GEMM as TILE x TILE tiles (mt outer, nt inner) and drives one tile at a time to the GEMM unit.
// Latency: gemm_start 1 cycle after start, next gemm_start / done 2 cycles after gemm_complete; zero-dim done 2 cycles after start.
// Backpressure: none; start is ignored while busy, each tile is a gemm_start pulse answered by one gemm_complete pulse.
module gemm_tile_sched #(
  parameter int ADDR_BITS = 10,
  parameter int TILE      = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [7:0]           cfg_k,
  input  logic [7:0]           cfg_m,
  input  logic [7:0]           cfg_n,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic                 gemm_start,
  input  logic                 gemm_complete,
  output logic [7:0]           gemm_k,
  output logic [7:0]           gemm_m,
  output logic [7:0]           gemm_n,
  output logic [ADDR_BITS-1:0] gemm_a_base,
  output logic [ADDR_BITS-1:0] gemm_b_base,
  output logic [ADDR_BITS-1:0] gemm_c_base,
  output logic [15:0]          tile_cnt
);

  localparam logic [7:0]           TILE_D = 8'(TILE);
  localparam logic [ADDR_BITS-1:0] TILE_A = ADDR_BITS'(TILE);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, DONE} state_t;

  state_t state_q, state_d;

  // Remaining rows/cols from the current tile's origin; N is kept to restart each row.
  logic [7:0]           n_q;
  logic [7:0]           rem_m_q, rem_n_q;
  logic [7:0]           rem_m_d, rem_n_d;
  logic [ADDR_BITS-1:0] a_base_d, b_base_d, k_a;
  logic                 abort_q;
  // Zero-dimension runs spend one extra cycle in DONE before the done pulse.
  logic                 hold_q;
  logic                 cfg_zero, row_end, last_tile, stop;

  function automatic logic [7:0] clip(input logic [7:0] rem);
    return (rem > TILE_D) ? TILE_D : rem;
  endfunction

  assign k_a       = ADDR_BITS'(gemm_k);
  assign cfg_zero  = (cfg_k == 8'd0) || (cfg_m == 8'd0) || (cfg_n == 8'd0);
  assign row_end   = (rem_n_q <= TILE_D);
  assign last_tile = row_end && (rem_m_q <= TILE_D);
  // An abort arriving in NEXT itself also stops before another tile is issued.
  assign stop      = abort_q || abort || last_tile;

  assign busy       = (state_q != IDLE);
  assign gemm_start = (state_q == ISSUE);
  assign done       = (state_q == DONE) && !hold_q;
  assign aborted    = done && abort_q;

  // Incremental next-tile position: step along the row, or wrap to the start of the next row.
  always_comb begin
    rem_m_d  = rem_m_q;
    rem_n_d  = rem_n_q - TILE_D;
    a_base_d = gemm_a_base;
    b_base_d = gemm_b_base + k_a;
    if (row_end) begin
      rem_m_d  = rem_m_q - TILE_D;
      rem_n_d  = n_q;
      a_base_d = gemm_a_base + k_a;
      b_base_d = '0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = cfg_zero ? DONE : ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (gemm_complete) state_d = NEXT;
      NEXT:    state_d = stop ? DONE : ISSUE;
      DONE:    if (!hold_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Run configuration, tile descriptor registers, tile counter and abort latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_q         <= '0;
      rem_m_q     <= '0;
      rem_n_q     <= '0;
      gemm_k      <= '0;
      gemm_m      <= '0;
      gemm_n      <= '0;
      gemm_a_base <= '0;
      gemm_b_base <= '0;
      gemm_c_base <= '0;
      tile_cnt    <= '0;
      abort_q     <= 1'b0;
      hold_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            n_q         <= cfg_n;
            rem_m_q     <= cfg_m;
            rem_n_q     <= cfg_n;
            gemm_k      <= cfg_k;
            gemm_m      <= clip(cfg_m);
            gemm_n      <= clip(cfg_n);
            gemm_a_base <= '0;
            gemm_b_base <= '0;
            gemm_c_base <= '0;
            tile_cnt    <= '0;
            abort_q     <= 1'b0;
            hold_q      <= cfg_zero;
          end
        end
        WAIT: begin
          if (gemm_complete) tile_cnt <= tile_cnt + 16'd1;
        end
        NEXT: begin
          if (!stop) begin
            rem_m_q     <= rem_m_d;
            rem_n_q     <= rem_n_d;
            gemm_m      <= clip(rem_m_d);
            gemm_n      <= clip(rem_n_d);
            gemm_a_base <= a_base_d;
            gemm_b_base <= b_base_d;
            gemm_c_base <= gemm_c_base + TILE_A;
          end
        end
        DONE: begin
          hold_q <= 1'b0;
        end
        default: ;
      endcase
      if ((state_q != IDLE) && abort) abort_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gemm_tile_sched.sv
// Randomized scoreboard bench for gemm_tile_sched with a behavioural tile-order model.
// Latency: checks issue/done timing against start and gemm_complete cycles.
// Backpressure: a GEMM-unit model answers each gemm_start with gemm_complete after a chosen delay.
module tb_gemm_tile_sched;

  localparam int AB    = 10;
  localparam int TILE  = 4;
  localparam int AMASK = (1 << AB) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          gemm_complete = 1'b0;
  logic [7:0]    cfg_k = '0, cfg_m = '0, cfg_n = '0;
  logic          busy, done, aborted, gemm_start;
  logic [7:0]    gemm_k, gemm_m, gemm_n;
  logic [AB-1:0] gemm_a_base, gemm_b_base, gemm_c_base;
  logic [15:0]   tile_cnt;

  gemm_tile_sched #(.ADDR_BITS(AB), .TILE(TILE)) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_k(cfg_k), .cfg_m(cfg_m), .cfg_n(cfg_n), .abort(abort),
    .busy(busy), .done(done), .aborted(aborted), .gemm_start(gemm_start),
    .gemm_complete(gemm_complete),
    .gemm_k(gemm_k), .gemm_m(gemm_m), .gemm_n(gemm_n),
    .gemm_a_base(gemm_a_base), .gemm_b_base(gemm_b_base), .gemm_c_base(gemm_c_base),
    .tile_cnt(tile_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { int k; int m; int n; int a; int b; int c; } tile_t;
  typedef struct { int aborted; int cnt; int zero; } done_t;

  tile_t exp_tiles[$];
  done_t exp_done[$];
  tile_t held;

  int checks = 0, errors = 0;
  int cyc = 0, cmp_cyc = 0, start_cyc = 0;
  int resp_lat = 3, rcnt = 0;
  int n_starts = 0, n_dones = 0;
  bit first_pending = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: enumerate tiles straight from the tiling rules.
  task automatic model_run(input int k, input int m, input int n, input int abort_tile);
    int mt_n, nt_n, total, limit, idx;
    tile_t t;
    done_t d;
    mt_n = 0; nt_n = 0; total = 0;
    if (k != 0 && m != 0 && n != 0) begin
      mt_n  = (m + TILE - 1) / TILE;
      nt_n  = (n + TILE - 1) / TILE;
      total = mt_n * nt_n;
    end
    limit = (abort_tile >= 0 && abort_tile < total) ? abort_tile + 1 : total;
    idx = 0;
    for (int mt = 0; mt < mt_n; mt++) begin
      for (int nt = 0; nt < nt_n; nt++) begin
        if (idx < limit) begin
          t.k = k;
          t.m = (m - mt * TILE < TILE) ? m - mt * TILE : TILE;
          t.n = (n - nt * TILE < TILE) ? n - nt * TILE : TILE;
          t.a = (mt * k) & AMASK;
          t.b = (nt * k) & AMASK;
          t.c = ((mt * nt_n + nt) * TILE) & AMASK;
          exp_tiles.push_back(t);
        end
        idx++;
      end
    end
    d.aborted = (abort_tile >= 0 && abort_tile < total) ? 1 : 0;
    d.cnt     = limit;
    d.zero    = (total == 0) ? 1 : 0;
    exp_done.push_back(d);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // GEMM unit model: one gemm_complete pulse resp_lat cycles after each gemm_start; reset clears it.
  initial forever begin
    @(negedge clk);
    #1;
    gemm_complete = 1'b0;
    if (reset) begin
      rcnt = 0;
    end else if (gemm_start) begin
      rcnt = resp_lat;
    end else if (rcnt > 0) begin
      rcnt--;
      if (rcnt == 0) begin
        gemm_complete = 1'b1;
        cmp_cyc = cyc;
      end
    end
  end

  // Monitor: pop the scoreboard on every gemm_start and done.
  initial forever begin
    tile_t t;
    done_t d;
    @(negedge clk);
    if (!reset) begin
      if (gemm_start) begin
        n_starts++;
        if (exp_tiles.size() == 0) begin
          check("unexpected_gemm_start", 1, 0);
        end else begin
          t = exp_tiles.pop_front();
          check("gemm_k", longint'(gemm_k), longint'(t.k));
          check("gemm_m", longint'(gemm_m), longint'(t.m));
          check("gemm_n", longint'(gemm_n), longint'(t.n));
          check("a_base", longint'(gemm_a_base), longint'(t.a));
          check("b_base", longint'(gemm_b_base), longint'(t.b));
          check("c_base", longint'(gemm_c_base), longint'(t.c));
          check("start_latency", longint'(cyc),
                longint'(first_pending ? start_cyc + 1 : cmp_cyc + 2));
          first_pending = 1'b0;
          held = t;
        end
      end
      if (gemm_complete) begin
        check("hold_dims", longint'({gemm_k, gemm_m, gemm_n}),
              longint'({8'(held.k), 8'(held.m), 8'(held.n)}));
        check("hold_bases", longint'({gemm_a_base, gemm_b_base, gemm_c_base}),
              longint'({AB'(held.a), AB'(held.b), AB'(held.c)}));
      end
      if (done) begin
        n_dones++;
        if (exp_done.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          d = exp_done.pop_front();
          check("aborted", longint'(aborted), longint'(d.aborted));
          check("tile_cnt", longint'(tile_cnt), longint'(d.cnt));
          check("done_latency", longint'(cyc),
                longint'((d.zero != 0) ? start_cyc + 2 : cmp_cyc + 2));
        end
      end
    end
  end

  task automatic check_reset_outputs(input string name);
    check({name, "_ctl"}, longint'({busy, done, aborted, gemm_start, gemm_k, gemm_m, gemm_n, tile_cnt}), 0);
    check({name, "_bases"}, longint'({gemm_a_base, gemm_b_base, gemm_c_base}), 0);
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    #1 check_reset_outputs("reset_now");
    exp_tiles.delete();
    exp_done.delete();
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic issue_start(input int k, input int m, input int n, output int base_s, output int base_d);
    @(negedge clk);
    cfg_k = 8'(k); cfg_m = 8'(m); cfg_n = 8'(n);
    start = 1'b1;
    start_cyc = cyc;
    first_pending = 1'b1;
    base_s = n_starts;
    base_d = n_dones;
    @(negedge clk);
    start = 1'b0;
    cfg_k = 8'($urandom); cfg_m = 8'($urandom); cfg_n = 8'($urandom);
  endtask

  task automatic run(input int k, input int m, input int n, input int lat, input int abort_tile, input bit glitch);
    int base_s, base_d, waited;
    bit ab_sent, gl_sent;
    ab_sent = 1'b0; gl_sent = 1'b0; waited = 0;
    model_run(k, m, n, abort_tile);
    resp_lat = lat;
    issue_start(k, m, n, base_s, base_d);
    while (n_dones == base_d && waited < 4000) begin
      @(negedge clk);
      waited++;
      abort = 1'b0;
      start = 1'b0;
      if (abort_tile >= 0 && !ab_sent && (n_starts - base_s) > abort_tile) begin
        abort = 1'b1;
        ab_sent = 1'b1;
      end
      if (glitch && !gl_sent && (n_starts - base_s) >= 1) begin
        start = 1'b1;
        cfg_k = 8'($urandom_range(1, 255)); cfg_m = 8'($urandom_range(1, 255)); cfg_n = 8'($urandom_range(1, 255));
        gl_sent = 1'b1;
      end
    end
    abort = 1'b0;
    start = 1'b0;
    if (waited >= 4000) begin
      check("done_timeout", 0, 1);
      pulse_reset();
    end
    @(negedge clk);
    check("tiles_left", longint'(exp_tiles.size()), 0);
    check("dones_left", longint'(exp_done.size()), 0);
    check("idle_after_done", longint'(busy), 0);
  endtask

  task automatic run_reset(input int k, input int m, input int n, input int lat, input int rst_tile);
    int base_s, base_d, waited;
    waited = 0;
    model_run(k, m, n, -1);
    resp_lat = lat;
    issue_start(k, m, n, base_s, base_d);
    while ((n_starts - base_s) <= rst_tile && waited < 4000) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 4000) check("reset_point_timeout", 0, 1);
    @(negedge clk);
    pulse_reset();
    @(negedge clk);
    check_reset_outputs("after_reset");
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, m, n, lat, ab;
    bit gl;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    #2 reset = 1'b0;
    @(negedge clk);

    run(8, 4, 4, 3, -1, 1'b0);      // single full tile
    run(3, 6, 5, 5, -1, 1'b0);      // ragged edges, 2x2 tiles
    run(4, 0, 4, 3, -1, 1'b0);      // zero M: no tiles
    run(0, 5, 5, 3, -1, 1'b0);      // zero K: no tiles
    run(2, 8, 8, 4, 1, 1'b0);       // abort in tile 1
    run(5, 6, 7, 4, -1, 1'b1);      // start while busy ignored
    run_reset(3, 16, 16, 4, 3);     // reset mid-run
    run(3, 16, 16, 2, -1, 1'b0);    // clean restart from tile 0
    run(255, 24, 24, 1, -1, 1'b0);  // base addresses wrap
    run(7, 5, 9, 3, 5, 1'b0);       // abort on the last tile

    for (int r = 0; r < 20; r++) begin
      k   = $urandom_range(1, 40);
      m   = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 20);
      n   = $urandom_range(1, 20);
      lat = $urandom_range(1, 6);
      ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : -1;
      gl  = ($urandom_range(0, 3) == 0);
      run(k, m, n, lat, ab, gl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gemm_tile_sched.md
GEMM_TILE_SCHED -- requirements
Module: gemm_tile_sched

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 10: width of the A/B/C buffer word addresses.
REQ-002 SHALL have parameter TILE, default 4: systolic array edge, i.e. the maximum tile rows and columns.
REQ-003 SHALL have port clk, input, 1: clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port start, input, 1: request to run one full GEMM; sampled only in IDLE.
REQ-006 SHALL have ports cfg_k, cfg_m, cfg_n, input, 8 each: problem dimensions; latched when start is accepted.
REQ-007 SHALL have port abort, input, 1: stop after the tile currently in flight.
REQ-008 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-009 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-010 SHALL have port aborted, output, 1: qualifies done; high when the run ended by abort.
REQ-011 SHALL have port gemm_start, output, 1: one-cycle start pulse to the GEMM unit.
REQ-012 SHALL have port gemm_complete, input, 1: tile finished, from the GEMM unit.
REQ-013 SHALL have ports gemm_k, gemm_m, gemm_n, output, 8 each: dimensions of the current tile.
REQ-014 SHALL have ports gemm_a_base, gemm_b_base, gemm_c_base, output, ADDR_BITS each: buffer base addresses of the current tile.
REQ-015 SHALL have port tile_cnt, output, 16: number of tiles completed in the current or last run.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT, NEXT, DONE.
REQ-017 IDLE, start=1: SHALL latch cfg_*, clear counters and tile_cnt, clear the abort latch.
  - Any of cfg_k/m/n == 0 -> DONE.
  - Otherwise -> ISSUE.
REQ-018 ISSUE: SHALL assert gemm_start for exactly one cycle, then go to WAIT.
REQ-019 WAIT: SHALL hold until gemm_complete=1, then go to NEXT and increment tile_cnt.
  - gemm_complete is ignored in every other state.
REQ-020 NEXT: SHALL go to DONE if the abort latch is set or the last tile is complete; otherwise SHALL advance the tile indices and go to ISSUE.
REQ-021 DONE: SHALL assert done for one cycle (aborted = abort latch), then go to IDLE.
REQ-022 Tile order SHALL be mt outer, nt inner.
  - MT = ceil(M/TILE), NT = ceil(N/TILE).
  - Last tile is (MT-1, NT-1).
REQ-023 gemm_m SHALL be min(TILE, M - mt*TILE), gemm_n SHALL be min(TILE, N - nt*TILE), gemm_k SHALL be K.
REQ-024 Base addresses SHALL be gemm_a_base = mt*K, gemm_b_base = nt*K, gemm_c_base = (mt*NT + nt)*TILE.
  - Computed incrementally (adders only, no multipliers).
  - All arithmetic truncated modulo 2^ADDR_BITS (wrap, no error).
REQ-025 gemm_k/m/n and gemm_*_base SHALL be registered and stable from ISSUE through WAIT.
REQ-026 Latency SHALL be:
  - gemm_start 1 cycle after start is accepted.
  - Next gemm_start 2 cycles after a gemm_complete.
  - done 2 cycles after the final gemm_complete.
  - For a zero dimension, done 2 cycles after start with no gemm_start.
REQ-027 start while busy SHALL be ignored; cfg_* changes while busy SHALL have no effect.
REQ-028 abort=1 in any busy state SHALL set the abort latch; the in-flight tile SHALL always be allowed to complete; abort in IDLE SHALL be ignored.
REQ-029 abort and gemm_complete in the same WAIT cycle SHALL give NEXT -> DONE with aborted=1.
REQ-030 abort in ISSUE SHALL still issue that tile and wait for its gemm_complete.

Reset
REQ-031 On reset the FSM SHALL be in IDLE, with busy, done, aborted and gemm_start = 0, all gemm_* outputs = 0, tile_cnt = 0 and the abort latch cleared.
REQ-032 Reset asserted mid-run SHALL abandon the run immediately, with no done pulse; the GEMM unit is reset by the same signal.

Verification
REQ-033 K=8, M=4, N=4, start -> one gemm_start, with gemm_m=4, gemm_n=4, gemm_k=8 and all bases 0; then done, aborted=0, tile_cnt=1.
REQ-034 K=3, M=6, N=5 -> four tiles, with completes returned after 5 cycles each:
  - gemm_m = 4,4,2,2
  - gemm_n = 4,1,4,1
  - a_base = 0,0,3,3
  - b_base = 0,3,0,3
  - c_base = 0,4,8,12
  - done with tile_cnt=4.
REQ-035 M=0 (K=N=4), start -> no gemm_start; done 2 cycles later; tile_cnt=0.
REQ-036 K=2, M=8, N=8, abort during WAIT of tile 1 -> tile 1 still completes; done with aborted=1, tile_cnt=2.
REQ-037 start pulsed during WAIT with different cfg -> ignored; the run finishes with the original dimensions and bases.
REQ-038 reset during WAIT of the 16-tile run (M=N=16) -> busy=0 and all outputs 0 immediately; a new start then runs normally from tile 0.
